// File: rtl/pla_pkg.sv
// rtl/pla_pkg.sv - shared constants and term-entry type for the PLA evaluation pipeline
package pla_pkg;

    localparam int PLA_N_IN   = 8;
    localparam int PLA_N_TERM = 16;
    localparam int PLA_N_OUT  = 4;

    typedef struct packed {
        logic                 en;
        logic [PLA_N_IN-1:0]  care;
        logic [PLA_N_IN-1:0]  val;
        logic [PLA_N_OUT-1:0] omask;
    } pla_term_t;

endpackage

// File: rtl/pla_term_row.sv
// rtl/pla_term_row.sv - one programmable product term: stored entry plus its fire compare
module pla_term_row
    import pla_pkg::*;
#(
    parameter int N_IN  = PLA_N_IN,
    parameter int N_OUT = PLA_N_OUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic             en_i,
    input  logic [N_IN-1:0]  care_i,
    input  logic [N_IN-1:0]  val_i,
    input  logic [N_OUT-1:0] omask_i,
    input  logic [N_IN-1:0]  x_i,
    output logic             fire_o,
    output logic [N_OUT-1:0] omask_o
);

    logic             en_q;
    logic [N_IN-1:0]  care_q;
    logic [N_IN-1:0]  val_q;
    logic [N_OUT-1:0] omask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else if (wr_i) begin
            en_q <= en_i;
        end
    end

    // Literal storage is left unreset: a disabled term never reaches the OR plane.
    always_ff @(posedge clk) begin
        if (wr_i) begin
            care_q  <= care_i;
            val_q   <= val_i;
            omask_q <= omask_i;
        end
    end

    assign fire_o  = en_q & (((x_i ^ val_q) & care_q) == '0);
    assign omask_o = omask_q;

endmodule

// File: rtl/pla_eval_pipe.sv
// rtl/pla_eval_pipe.sv - two-stage PLA evaluator: fired-term stage, OR-plane stage, handshakes
module pla_eval_pipe
    import pla_pkg::*;
#(
    parameter int N_IN   = PLA_N_IN,
    parameter int N_TERM = PLA_N_TERM,
    parameter int N_OUT  = PLA_N_OUT,
    localparam int AW    = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic             cfg_en,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic [N_OUT-1:0] cfg_omask,
    output logic             cfg_ack,
    output logic             idle
);

    logic              s1_valid_q;
    logic              s2_valid_q;
    logic              cfg_ack_q;
    logic [N_TERM-1:0] s1_fire_q;
    logic [N_OUT-1:0]  out_data_q;

    logic              s1_adv;
    logic              s2_adv;
    logic              accept;
    logic              cfg_take;
    logic [N_TERM-1:0] fire_vec;
    logic [N_OUT-1:0]  term_omask [N_TERM];
    logic [N_OUT-1:0]  y_d;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv & ~cfg_we;
    assign accept   = in_valid & in_ready;
    assign idle     = ~s1_valid_q & ~s2_valid_q;

    // Table writes only land on an empty pipe, so in-flight vectors never see a half-updated table.
    assign cfg_take = cfg_we & idle & (32'(cfg_addr) < N_TERM);

    for (genvar t = 0; t < N_TERM; t++) begin : g_row
        pla_term_row #(
            .N_IN  (N_IN),
            .N_OUT (N_OUT)
        ) u_row (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_i    (cfg_take && (32'(cfg_addr) == t)),
            .en_i    (cfg_en),
            .care_i  (cfg_care),
            .val_i   (cfg_val),
            .omask_i (cfg_omask),
            .x_i     (in_data),
            .fire_o  (fire_vec[t]),
            .omask_o (term_omask[t])
        );
    end

    always_comb begin
        y_d = '0;
        for (int t = 0; t < N_TERM; t++) begin
            if (s1_fire_q[t]) begin
                y_d = y_d | term_omask[t];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_fire_q  <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            cfg_ack_q  <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_take;
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_fire_q <= fire_vec;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= y_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign cfg_ack   = cfg_ack_q;

endmodule

// File: tb/tb_pla_eval_pipe.sv
// tb/tb_pla_eval_pipe.sv - self-checking bench for pla_eval_pipe with a reference model
module tb_pla_eval_pipe;

    localparam int NI = 8;
    localparam int NT = 4;
    localparam int NO = 2;

    typedef struct {
        logic [NI-1:0] x;
        logic [NO-1:0] y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NI-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NO-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_addr = '0;
    logic          cfg_en = 1'b0;
    logic [NI-1:0] cfg_care = '0;
    logic [NI-1:0] cfg_val = '0;
    logic [NO-1:0] cfg_omask = '0;
    logic          cfg_ack;
    logic          idle;

    pla_eval_pipe #(.N_IN(NI), .N_TERM(NT), .N_OUT(NO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_en    (cfg_en),
        .cfg_care  (cfg_care),
        .cfg_val   (cfg_val),
        .cfg_omask (cfg_omask),
        .cfg_ack   (cfg_ack),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the term table as plain arrays, results as an ordered queue.
    logic          m_en   [NT];
    logic [NI-1:0] m_care [NT];
    logic [NI-1:0] m_val  [NT];
    logic [NO-1:0] m_om   [NT];
    logic [NO-1:0] sb_q[$];
    int            sb_t[$];
    logic [NO-1:0] out_log[$];
    int            edge_cnt = 0;

    function automatic logic [NO-1:0] ref_eval(input logic [NI-1:0] x);
        logic [NO-1:0] y;
        y = '0;
        for (int t = 0; t < NT; t++) begin
            if (m_en[t] && ((x & m_care[t]) == (m_val[t] & m_care[t]))) y = y | m_om[t];
        end
        return y;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        int   n;
        logic fv;
        logic ir;
        logic ack_exp;
        ack_exp = 1'b0;
        for (int t = 0; t < NT; t++) m_en[t] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_exp = 1'b0;
                sb_q.delete();
                sb_t.delete();
                for (int t = 0; t < NT; t++) m_en[t] = 1'b0;
            end else begin
                n  = sb_q.size();
                ir = !cfg_we && (n < 2 || out_ready);
                fv = (n > 0) && (edge_cnt >= sb_t[0] + 1);
                chk("idle", idle, n == 0);
                chk("in_ready", in_ready, ir);
                chk("out_valid", out_valid, fv);
                chk("cfg_ack", cfg_ack, ack_exp);
                ack_exp = 1'b0;
                if (fv && out_ready) begin
                    chk("out_data", out_data, sb_q[0]);
                    out_log.push_back(out_data);
                    void'(sb_q.pop_front());
                    void'(sb_t.pop_front());
                end
                if (in_valid && ir) begin
                    sb_q.push_back(ref_eval(in_data));
                    sb_t.push_back(edge_cnt + 1);
                end
                if (cfg_we && n == 0 && int'(cfg_addr) < NT) begin
                    m_en[cfg_addr]   = cfg_en;
                    m_care[cfg_addr] = cfg_care;
                    m_val[cfg_addr]  = cfg_val;
                    m_om[cfg_addr]   = cfg_omask;
                    ack_exp = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [NI-1:0] x);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic e, input logic [NI-1:0] c,
                             input logic [NI-1:0] v, input logic [NO-1:0] om, input logic exp_ack);
        cfg_we = 1'b1; cfg_addr = a; cfg_en = e; cfg_care = c; cfg_val = v; cfg_omask = om;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_ack_pulse", cfg_ack, exp_ack);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n);
        int g;
        g = 0;
        while (out_log.size() < n && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("wait_log", out_log.size(), n);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!idle && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("wait_idle", idle, 1);
    endtask

    vec_t          tab[6];
    logic [NI-1:0] v41[4];
    logic [NO-1:0] e41[4];
    int            acc;
    int            acc_n;

    initial begin
        tab[0] = '{x: 8'hA5, y: 2'b11};
        tab[1] = '{x: 8'hA4, y: 2'b10};
        tab[2] = '{x: 8'h05, y: 2'b11};
        tab[3] = '{x: 8'hFF, y: 2'b10};
        tab[4] = '{x: 8'h00, y: 2'b10};
        tab[5] = '{x: 8'h35, y: 2'b11};
        v41[0] = 8'hA5; v41[1] = 8'h00; v41[2] = 8'h15; v41[3] = 8'h3C;
        e41[0] = 2'b11; e41[1] = 2'b10; e41[2] = 2'b11; e41[3] = 2'b10;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty table: everything evaluates to zero, two edges after acceptance.
        chk("idle_before_first", idle, 1);
        send(8'hFF);
        @(negedge clk);
        chk("lat_k1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_k2_valid", out_valid, 1);
        chk("lat_k2_data", out_data, 2'b00);
        @(posedge clk);
        #1;

        cfg_write(2'd0, 1'b1, 8'h0F, 8'h05, 2'b01, 1'b1);
        send(8'hA5);
        send(8'hA4);
        @(negedge clk);
        chk("b2b_first", {31'd0, out_valid} << 4 | 32'(out_data), 32'h12 - 32'h1);
        @(negedge clk);
        chk("b2b_second", {31'd0, out_valid} << 4 | 32'(out_data), 32'h10);
        @(posedge clk);
        #1;

        // Backpressure: only the two stage registers can absorb input while stalled.
        cfg_write(2'd1, 1'b1, 8'h00, 8'h00, 2'b10, 1'b1);
        wait_idle();
        out_log.delete();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = v41[acc];
            @(negedge clk);
            acc_n = in_ready ? acc + 1 : acc;
            @(posedge clk);
            #1 acc = acc_n;
        end
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_accepted", acc, 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(v41[2]);
        send(v41[3]);
        wait_log(4);
        for (int i = 0; i < 4; i++) chk($sformatf("stall_order%0d", i), out_log[i], e41[i]);

        wait_idle();
        out_log.delete();
        for (int i = 0; i < 6; i++) send(tab[i].x);
        wait_log(6);
        for (int i = 0; i < 6; i++) chk($sformatf("tab%0d", i), out_log[i], tab[i].y);

        // Write attempted while a vector sits in S1 must be dropped.
        wait_idle();
        out_log.delete();
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_en = 1'b1; cfg_care = 8'hFF; cfg_val = 8'h00; cfg_omask = 2'b01;
        @(negedge clk);
        chk("busy_idle", idle, 0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
        chk("busy_cfg_ack", cfg_ack, 0);
        @(posedge clk);
        #1;
        wait_log(1);
        chk("busy_result", out_log[0], 2'b10);
        wait_idle();
        out_log.delete();
        send(8'h00);
        wait_log(1);
        chk("t2_unchanged", out_log[0], 2'b10);
        wait_idle();
        cfg_write(2'd2, 1'b1, 8'hFF, 8'h00, 2'b01, 1'b1);
        out_log.delete();
        send(8'h00);
        wait_log(1);
        chk("t2_retry", out_log[0], 2'b11);

        // Config and input offered together: config first, vector next cycle with the new term.
        wait_idle();
        out_log.delete();
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_en = 1'b1; cfg_care = 8'hFF; cfg_val = 8'hC3; cfg_omask = 2'b01;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        chk("prio_in_ready0", in_ready, 0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
        chk("prio_in_ready1", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_log(1);
        chk("prio_new_entry", out_log[0], 2'b11);

        // Asynchronous reset with both stages full.
        wait_idle();
        out_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_idle", idle, 1);
        chk("arst_out_data", out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        out_log.delete();
        send(8'hA5);
        wait_log(1);
        chk("post_rst_result", out_log[0], 2'b00);

        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_addr  = 2'($urandom);
            cfg_en    = ($urandom_range(0, 3) != 0);
            cfg_care  = 8'($urandom & $urandom);
            cfg_val   = 8'($urandom);
            cfg_omask = 2'($urandom);
            @(posedge clk);
            #1;
        end
        cfg_we    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("final_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pla_eval_pipe.md
PLA_EVAL_PIPE -- requirements
Module: pla_eval_pipe

Interface
REQ-001 Parameter: N_IN, 8, width of the input vector.
REQ-002 Parameter: N_TERM, 16, number of programmable product terms; minimum 1.
REQ-003 Parameter: N_OUT, 4, number of outputs.
REQ-004 Port: clk  input  1  sole clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: in_valid  input  1  input vector offered.
REQ-007 Port: in_ready  output  1  input vector accepted when in_valid & in_ready.
REQ-008 Port: in_data  input  N_IN  input vector x.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  result consumed when out_valid & out_ready.
REQ-011 Port: out_data  output  N_OUT  result vector y.
REQ-012 Port: cfg_we  input  1  term-table write request.
REQ-013 Port: cfg_addr  input  max(1,$clog2(N_TERM))  term index.
REQ-014 Port: cfg_en  input  1  term enable bit to write.
REQ-015 Port: cfg_care  input  N_IN  care mask; 0 = don't-care literal.
REQ-016 Port: cfg_val  input  N_IN  required literal polarity where care is 1.
REQ-017 Port: cfg_omask  input  N_OUT  OR-plane connection of the term to each output.
REQ-018 Port: cfg_ack  output  1  one-cycle pulse, write taken.
REQ-019 Port: idle  output  1  both pipeline stages empty.

Function
REQ-020 Term t SHALL fire iff en[t] and ((x & care[t]) == (val[t] & care[t])); an enabled term with care = 0 fires always.
REQ-021 y[j] SHALL be the OR over fired t of omask[t][j]; with no fired term, y = 0.
REQ-022 Stage S1 SHALL register the N_TERM fired-term vector; stage S2 SHALL register y.
REQ-023 Latency: vector accepted at edge k SHALL appear with out_valid at edge k+2 when not stalled.
REQ-024 Throughput SHALL be one vector per cycle with out_ready held high.
REQ-025 s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv & ~cfg_we.
REQ-026 On stall, S1/S2 contents and out_data SHALL hold stable; no vector dropped, duplicated or reordered.
REQ-027 A write SHALL be taken only when cfg_we & idle; the table entry updates at that edge and cfg_ack pulses high the next cycle.
REQ-028 cfg_we while not idle SHALL be ignored: no table change, cfg_ack low; the requester retries.
REQ-029 cfg_we and in_valid together SHALL give config priority (in_ready low that cycle).
REQ-030 A vector accepted after a taken write SHALL use the new entry.
REQ-031 cfg_addr >= N_TERM SHALL be ignored, cfg_ack low.
REQ-032 idle = ~s1_valid & ~s2_valid.

Reset
REQ-033 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid, cfg_ack, out_data, and all en[t]; idle = 1.
REQ-034 care, val, omask storage need not be reset; while en = 0 it does not affect y.
REQ-035 Reset mid-stream SHALL discard in-flight vectors; out_valid first rises 2 cycles after the first post-reset acceptance.

Structure
REQ-036 Shared package pla_pkg SHALL hold default parameter constants and the term-entry struct (en, care, val, omask).
REQ-037 Sub-module pla_term_row SHALL hold one term entry and its fire compare; instantiated N_TERM times.
REQ-038 The OR plane, stage registers and handshake logic SHALL reside in pla_eval_pipe.

Verification (N_IN=8, N_TERM=4, N_OUT=2)
REQ-039 Reset, no config, in_data=8'hFF -> out_data=2'b00 at edge k+2; idle=1 before the first input.
REQ-040 Write t0 care=8'h0F val=8'h05 omask=2'b01 en=1 -> cfg_ack pulse; inputs 8'hA5, 8'hA4 back-to-back -> 2'b01, 2'b00 on consecutive cycles.
REQ-041 Write t1 care=8'h00 omask=2'b10 en=1; out_ready low 5 cycles with 4 vectors offered -> exactly 2 accepted, in_ready low; release -> 2'b10/2'b11 results in order, no loss.
REQ-042 cfg_we for t2 while s1_valid=1 -> cfg_ack=0, t2 unchanged; retry when idle -> cfg_ack=1.
REQ-043 rst_n low while S1 and S2 are full -> out_valid=0 asynchronously; after release, 8'hA5 -> 2'b00 (table disabled).
REQ-044 cfg_we together with in_valid -> in_ready=0 that cycle; the vector is accepted next cycle and evaluated with the new entry.
